mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter that shares the single-port traffic-statistics memory between up to N_REQ system-bus requesters: controller, rank calculator and traffic light.
- Accepts one request at a time, drives the memory port (READ/WRITE, address, write data), waits the memory read latency and returns read data with a one-cycle ACK pulse.
- Sits between the requesters and the memory block inside the system-bus top.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 1, memory read latency in cycles (>=1); MEM_RDATA is valid RD_LAT cycles after the issue cycle.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ  input  N_REQ  per-requester request level; held until ACK.
- REQ_OP  input  N_REQ  per-requester operation: 0=READ, 1=WRITE.
- REQ_ADDR  input  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- REQ_WDATA  input  N_REQ*DATA_W  packed write data, same packing.
- ACK  output  N_REQ  one-hot, one-cycle completion pulse.
- RDATA  output  DATA_W  read data; valid only while ACK is set for a READ.
- BUSY  output  1  high in every state other than IDLE.
- MEM_EN  output  1  memory access strobe, exactly one cycle per transaction.
- MEM_OP  output  1  0=READ, 1=WRITE.
- MEM_ADDR  output  ADDR_W  memory address.
- MEM_WDATA  output  DATA_W  memory write data.
- MEM_RDATA  input  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock (CLK); reset RST_N is asynchronous, active-low.
- Reset values: state=IDLE, round-robin pointer=0; ACK, RDATA, BUSY, MEM_EN, MEM_OP, MEM_ADDR and MEM_WDATA are all 0.
- Reset asserted mid-transaction aborts it immediately. No ACK is produced, and the requester must re-request.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any REQ bit is high, pick the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Latch the winner's index, op, address and write data, then go to ISSUE.
  - If no REQ bit is high, stay in IDLE.
- ISSUE (1 cycle): MEM_EN=1; MEM_OP, MEM_ADDR and MEM_WDATA carry the latched values. Pointer becomes winner+1 (wrapping). Next state is WAIT for a READ, RESP for a WRITE.
- WAIT (RD_LAT cycles, down-counter): MEM_EN=0. On the closing edge of the last WAIT cycle, capture MEM_RDATA into RDATA, then go to RESP.
- RESP (1 cycle): ACK[winner]=1, then go to IDLE. For a WRITE, RDATA holds its previous value.
- Latency from REQ sampled in IDLE at cycle t:
  - WRITE: issue at t+1, ACK at t+2.
  - READ: issue at t+1, ACK at t+2+RD_LAT.
- Handshake:
  - The requester keeps REQ and its op/address/data stable until it sees ACK.
  - It deasserts REQ on the edge that ends the ACK cycle. A REQ still high in the following IDLE cycle is a new request.
- Latched operands: changes to REQ_* after the IDLE capture edge are ignored for the current transaction.
- Requester drops REQ mid-transaction: the transaction still completes and ACK still pulses.
- Simultaneous requests: exactly one is granted per transaction; the others wait in order, so each pending requester is served within N_REQ transactions (no starvation).
- Pointer wrap: after granting index N_REQ-1 the pointer returns to 0.
- MEM_EN is never high in two consecutive cycles; bus gap is at least 2 cycles per transaction.
- MEM_OP, MEM_ADDR and MEM_WDATA keep their last values when MEM_EN=0.

Test Plan:
- Reset/idle: RST_N=0, then release with REQ=000 → all outputs 0, BUSY=0, MEM_EN never pulses.
- Single write: REQ[1]=1, REQ_OP[1]=1, addr 4'h5, data 8'hA7 → MEM_EN, MEM_OP=1, MEM_ADDR=5 and MEM_WDATA=A7 at t+1; ACK=010 at t+2.
- Single read: memory preloaded with 8'h3C at address 2, REQ[0] READ addr 2 → ACK=001 at t+3 (RD_LAT=1) with RDATA=3C. Repeat with RD_LAT=3 → ACK at t+5.
- Round-robin: REQ=111 held continuously (each requester re-requests after its ACK) → grant order 0,1,2,0,1,2. Then REQ=101 after granting 0 → next grant is 2, then 0.
- Reset mid-read: assert RST_N=0 during WAIT → outputs clear asynchronously, no ACK. After release, a re-request completes normally with pointer=0.
- Request withdrawn: REQ[2] dropped during ISSUE → ACK[2] still pulses in RESP, and the next IDLE does not regrant 2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Round-robin arbiter sharing one single-port statistics memory between
// N_REQ system-bus requesters. One request is served at a time:
//   IDLE  -> pick the next requester (round-robin) and latch its operands
//   ISSUE -> one-cycle memory strobe (MEM_EN) with the latched operands
//   WAIT  -> READ only: RD_LAT cycles, then capture MEM_RDATA into RDATA
//   RESP  -> one-cycle ACK pulse to the winner
//
// Ports:
//   CLK, RST_N         clock (rising edge), asynchronous active-low reset
//   REQ, REQ_OP        per-requester request level and op (0=READ, 1=WRITE)
//   REQ_ADDR/REQ_WDATA packed per-requester address / write data
//   ACK, RDATA         one-hot completion pulse, read data (valid with ACK)
//   BUSY               high whenever the arbiter is not in IDLE
//   MEM_EN/OP/ADDR/WDATA  memory port, MEM_RDATA  memory read data
//
// All outputs are registered: their next values are computed together with
// the next state, so an output is valid in the same cycle as its state.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_REQ-1:0]           REQ,
    input  logic [N_REQ-1:0]           REQ_OP,
    input  logic [N_REQ*ADDR_W-1:0]    REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0]    REQ_WDATA,
    output logic [N_REQ-1:0]           ACK,
    output logic [DATA_W-1:0]          RDATA,
    output logic                       BUSY,
    output logic                       MEM_EN,
    output logic                       MEM_OP,
    output logic [ADDR_W-1:0]          MEM_ADDR,
    output logic [DATA_W-1:0]          MEM_WDATA,
    input  logic [DATA_W-1:0]          MEM_RDATA
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_op_q, mem_op_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Round-robin pick results
    logic                found_s;
    logic [IDX_W-1:0]    pick_s;

    // Unpacked views of the packed requester operand buses
    logic [ADDR_W-1:0]   req_addr_a  [N_REQ];
    logic [DATA_W-1:0]   req_wdata_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_addr_a[g]  = REQ_ADDR[g*ADDR_W +: ADDR_W];
        assign req_wdata_a[g] = REQ_WDATA[g*DATA_W +: DATA_W];
    end

    // Round-robin search: first set REQ bit at or after ptr_q, wrapping modulo N_REQ
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        logic             hit;
        found_s  = 1'b0;
        pick_s   = {IDX_W{1'b0}};
        cand     = 32'd0;
        cand_idx = {IDX_W{1'b0}};
        hit      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = 32'(ptr_q) + 32'(k);
            cand     = (cand >= 32'(N_REQ)) ? (cand - 32'(N_REQ)) : cand;
            cand_idx = IDX_W'(cand);
            hit      = REQ[cand_idx] & ~found_s;
            pick_s   = hit ? cand_idx : pick_s;
            found_s  = found_s | REQ[cand_idx];
        end
    end

    // Next-state and next-output logic of the arbitration FSM
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        ack_d       = {N_REQ{1'b0}};
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    // The MEM_* registers double as the latched operands,
                    // so later REQ_* changes cannot affect this transaction.
                    win_d       = pick_s;
                    mem_en_d    = 1'b1;
                    mem_op_d    = REQ_OP[pick_s];
                    mem_addr_d  = req_addr_a[pick_s];
                    mem_wdata_d = req_wdata_a[pick_s];
                    state_d     = ST_ISSUE;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}}
                                                     : (win_q + IDX_W'(1));
                if (mem_op_q) begin
                    // WRITE: no data to wait for, acknowledge next cycle
                    ack_d[win_q] = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    // Last latency cycle: MEM_RDATA is valid now
                    rdata_d      = MEM_RDATA;
                    ack_d[win_q] = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops; reset aborts any transaction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {IDX_W{1'b0}};
            win_q       <= {IDX_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ack_q       <= {N_REQ{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_op_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ACK       = ack_q;
    assign RDATA     = rdata_q;
    assign BUSY      = busy_q;
    assign MEM_EN    = mem_en_q;
    assign MEM_OP    = mem_op_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Table-driven bench for mem_bus_arbiter (N_REQ=3, ADDR_W=4, DATA_W=8).
// dut uses RD_LAT=1, dut3 uses RD_LAT=3. Each has a small memory model whose
// read pipeline returns 8'hEE in every cycle except the one where the data
// is due, so a capture on the wrong cycle shows up as wrong RDATA.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. they show the state of the current cycle.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rst3_n, mem_load;

    logic [2:0]  req, req_op;
    logic [11:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  ack;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic        busy, mem_en, mem_op;
    logic [3:0]  mem_addr;

    logic [2:0]  req3, req_op3;
    logic [11:0] req_addr3;
    logic [23:0] req_wdata3;
    logic [2:0]  ack3;
    logic [7:0]  rdata3, mem_wdata3, mem_rdata3;
    logic        busy3, mem_en3, mem_op3;
    logic [3:0]  mem_addr3;

    logic [7:0]  mem  [16];
    logic [7:0]  mem3 [16];
    logic [7:0]  rd1, r3a, r3b, r3c;

    int checks   = 0;
    int failures = 0;

    mem_bus_arbiter #(.N_REQ(3), .ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .REQ_OP(req_op),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .ACK(ack), .RDATA(rdata),
        .BUSY(busy), .MEM_EN(mem_en), .MEM_OP(mem_op), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
    );

    mem_bus_arbiter #(.N_REQ(3), .ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut3 (
        .CLK(clk), .RST_N(rst3_n), .REQ(req3), .REQ_OP(req_op3),
        .REQ_ADDR(req_addr3), .REQ_WDATA(req_wdata3), .ACK(ack3), .RDATA(rdata3),
        .BUSY(busy3), .MEM_EN(mem_en3), .MEM_OP(mem_op3), .MEM_ADDR(mem_addr3),
        .MEM_WDATA(mem_wdata3), .MEM_RDATA(mem_rdata3)
    );

    always #5 clk = ~clk;

    // Memory model for dut: preload, write port, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
            mem[2] <= 8'h3C;
        end else if (mem_en && mem_op) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd1 <= (mem_en && !mem_op) ? mem[mem_addr] : 8'hEE;
    end
    assign mem_rdata = rd1;

    // Memory model for dut3: preload, write port, 3-cycle read latency
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem3[i] <= 8'h10 + 8'(i);
            mem3[2] <= 8'h3C;
        end else if (mem_en3 && mem_op3) begin
            mem3[mem_addr3] <= mem_wdata3;
        end
        r3a <= (mem_en3 && !mem_op3) ? mem3[mem_addr3] : 8'hEE;
        r3b <= r3a;
        r3c <= r3b;
    end
    assign mem_rdata3 = r3c;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  op;
        logic [11:0] addr;
        logic [23:0] wdata;
        logic [2:0]  exp_ack;
        logic        exp_op;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_wd;
        logic [7:0]  exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs must already be applied in an IDLE cycle; runs one transaction
    // on dut and leaves the bench in the following IDLE cycle.
    task automatic run_txn(input string tag, input logic [2:0] e_ack, input logic e_op,
                           input logic [3:0] e_addr, input logic [7:0] e_wd,
                           input logic [7:0] e_rd, input int e_lat, input bit drop);
        int lat;
        tick();
        check({tag, "_issue_en"},    32'(mem_en),    32'd1);
        check({tag, "_issue_op"},    32'(mem_op),    32'(e_op));
        check({tag, "_issue_addr"},  32'(mem_addr),  32'(e_addr));
        check({tag, "_issue_wdata"}, 32'(mem_wdata), 32'(e_wd));
        check({tag, "_issue_busy"},  32'(busy),      32'd1);
        if (drop) req = 3'b000;
        lat = 1;
        do begin
            tick();
            lat++;
            check({tag, "_gap_en"}, 32'(mem_en), 32'd0);
        end while (ack == 3'b000 && lat < 12);
        check({tag, "_latency"}, 32'(lat),   32'(e_lat));
        check({tag, "_ack"},     32'(ack),   32'(e_ack));
        check({tag, "_rdata"},   32'(rdata), 32'(e_rd));
        check({tag, "_ack_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_ack_pulse"}, 32'(ack),  32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        // req, op, addr{2,1,0}, wdata{2,1,0} | ack, op, addr, wdata, rdata, latency
        vecs[0]  = '{3'b001, 3'b000, 12'h002, 24'h000000, 3'b001, 1'b0, 4'h2, 8'h00, 8'h3C, 3};
        vecs[1]  = '{3'b010, 3'b010, 12'h050, 24'h00A700, 3'b010, 1'b1, 4'h5, 8'hA7, 8'h3C, 2};
        vecs[2]  = '{3'b100, 3'b100, 12'h900, 24'h5A0000, 3'b100, 1'b1, 4'h9, 8'h5A, 8'h3C, 2};
        vecs[3]  = '{3'b111, 3'b100, 12'h395, 24'hC30000, 3'b001, 1'b0, 4'h5, 8'h00, 8'hA7, 3};
        vecs[4]  = '{3'b111, 3'b100, 12'h395, 24'hC30000, 3'b010, 1'b0, 4'h9, 8'h00, 8'h5A, 3};
        vecs[5]  = '{3'b111, 3'b100, 12'h395, 24'hC30000, 3'b100, 1'b1, 4'h3, 8'hC3, 8'h5A, 2};
        vecs[6]  = '{3'b111, 3'b100, 12'h395, 24'hC30000, 3'b001, 1'b0, 4'h5, 8'h00, 8'hA7, 3};
        vecs[7]  = '{3'b111, 3'b100, 12'h395, 24'hC30000, 3'b010, 1'b0, 4'h9, 8'h00, 8'h5A, 3};
        vecs[8]  = '{3'b111, 3'b100, 12'h395, 24'hC30000, 3'b100, 1'b1, 4'h3, 8'hC3, 8'h5A, 2};
        vecs[9]  = '{3'b111, 3'b100, 12'h395, 24'hC30000, 3'b001, 1'b0, 4'h5, 8'h00, 8'hA7, 3};
        vecs[10] = '{3'b101, 3'b100, 12'h395, 24'hC30000, 3'b100, 1'b1, 4'h3, 8'hC3, 8'hA7, 2};
        vecs[11] = '{3'b101, 3'b100, 12'h395, 24'hC30000, 3'b001, 1'b0, 4'h5, 8'h00, 8'hA7, 3};
        vecs[12] = '{3'b010, 3'b000, 12'h030, 24'h000000, 3'b010, 1'b0, 4'h3, 8'h00, 8'hC3, 3};
        vecs[13] = '{3'b011, 3'b000, 12'h395, 24'h000000, 3'b001, 1'b0, 4'h5, 8'h00, 8'hA7, 3};

        rst_n = 1'b0; rst3_n = 1'b0; mem_load = 1'b1;
        req = 3'b000; req_op = 3'b000; req_addr = 12'h000; req_wdata = 24'h000000;
        req3 = 3'b000; req_op3 = 3'b000; req_addr3 = 12'h000; req_wdata3 = 24'h000000;
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;

        // Reset values
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_en",    32'(mem_en),    32'd0);
        check("rst_op",    32'(mem_op),    32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_rdata", 32'(rdata),     32'd0);
        check("rst_busy3", 32'(busy3),     32'd0);
        rst_n = 1'b1; rst3_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_en",   32'(mem_en), 32'd0);
            check("idle_busy", 32'(busy),   32'd0);
            check("idle_ack",  32'(ack),    32'd0);
        end

        // Directed vectors: single ops, round-robin, REQ=101 skip, pointer wrap
        for (int v = 0; v < 14; v++) begin
            req       = vecs[v].req;
            req_op    = vecs[v].op;
            req_addr  = vecs[v].addr;
            req_wdata = vecs[v].wdata;
            run_txn($sformatf("v%0d", v), vecs[v].exp_ack, vecs[v].exp_op, vecs[v].exp_addr,
                    vecs[v].exp_wd, vecs[v].exp_rd, vecs[v].exp_lat, 1'b0);
        end

        // Reset in the middle of a read from requester 0 (pointer moves to 1)
        req = 3'b001; req_op = 3'b000; req_addr = 12'h395; req_wdata = 24'h000000;
        tick();                 // ISSUE
        tick();                 // WAIT
        check("midrd_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrd_rst_busy",  32'(busy),      32'd0);
        check("midrd_rst_en",    32'(mem_en),    32'd0);
        check("midrd_rst_addr",  32'(mem_addr),  32'd0);
        check("midrd_rst_rdata", 32'(rdata),     32'd0);
        check("midrd_rst_ack",   32'(ack),       32'd0);
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrd_no_ack", 32'(ack), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("midrd_post_busy", 32'(busy), 32'd0);
        // Pointer must be back at 0: all three request, requester 0 wins
        req = 3'b111; req_op = 3'b000; req_addr = 12'h395; req_wdata = 24'h000000;
        run_txn("post_rst", 3'b001, 1'b0, 4'h5, 8'h00, 8'hA7, 3, 1'b0);

        // Requester 2 withdraws its write during ISSUE; it still gets ACK
        req = 3'b100; req_op = 3'b100; req_addr = 12'h700; req_wdata = 24'h660000;
        run_txn("withdraw", 3'b100, 1'b1, 4'h7, 8'h66, 8'hA7, 2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("withdraw_no_regrant_en",   32'(mem_en), 32'd0);
            check("withdraw_no_regrant_busy", 32'(busy),   32'd0);
        end

        // RD_LAT=3 read on dut3: ACK at t+5 with preloaded data
        req3 = 3'b001; req_op3 = 3'b000; req_addr3 = 12'h002; req_wdata3 = 24'h000000;
        tick();
        check("lat3_issue_en",   32'(mem_en3),   32'd1);
        check("lat3_issue_addr", 32'(mem_addr3), 32'd2);
        lat = 1;
        do begin
            tick();
            lat++;
            check("lat3_gap_en", 32'(mem_en3), 32'd0);
        end while (ack3 == 3'b000 && lat < 12);
        check("lat3_latency", 32'(lat),    32'd5);
        check("lat3_ack",     32'(ack3),   32'd1);
        check("lat3_rdata",   32'(rdata3), 32'h3C);
        req3 = 3'b000;
        tick();
        check("lat3_ack_pulse", 32'(ack3),  32'd0);
        check("lat3_idle_busy", 32'(busy3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
